// File: rtl/scrambler_ctrl.sv
// -----------------------------------------------------------------------------
// scrambler_ctrl
// Frame controller for a 10-bit word scrambler datapath. A start pulse in IDLE
// latches the 64-bit LFSR seed and the frame length, writes the two seed words
// into the datapath (0x068 = seed[31:0], 0x069 = seed[63:32]), then streams
// words from the input handshake into the datapath until the frame length is
// reached, and finally pulses done for one cycle.
//
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   start               : frame start pulse, honoured only in IDLE
//   cfg_seed_lo/hi      : LFSR seed words [31:0] / [63:32]
//   cfg_blk_len         : words per frame, 0 means 256
//   s_valid/s_data      : input word stream, s_ready back-pressure
//   sel_enable/sel_bits : per-word step request and bits to the datapath
//   sel_write/sel_addr/sel_lfsrdin : seed register write port
//   busy, done, word_cnt: status
//   frame_cnt           : completed frame counter (only with SCR_FRAME_CNT_EN)
//
// Build option: define SCR_FRAME_CNT_EN to add the 16-bit frame_cnt output.
// -----------------------------------------------------------------------------
module scrambler_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] cfg_seed_lo,
    input  logic [31:0] cfg_seed_hi,
    input  logic [7:0]  cfg_blk_len,
    input  logic        s_valid,
    input  logic [9:0]  s_data,
    output logic        s_ready,
    output logic        sel_enable,
    output logic [9:0]  sel_bits,
    output logic        sel_write,
    output logic [11:0] sel_addr,
    output logic [31:0] sel_lfsrdin,
    output logic        busy,
    output logic        done,
    output logic [7:0]  word_cnt
`ifdef SCR_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED_LO = 3'd1,
        ST_SEED_HI = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] seed_lo_q, seed_lo_d;
    logic [31:0] seed_hi_q, seed_hi_d;
    logic [7:0]  blk_len_q, blk_len_d;
    logic [7:0]  word_cnt_q, word_cnt_d;

    logic        ready_s;
    logic        accept_s;
    logic        last_s;
    logic        sel_write_s;
    logic [11:0] sel_addr_s;
    logic [31:0] sel_lfsrdin_s;
    logic        busy_s;
    logic        done_s;

    assign accept_s = s_valid & ready_s;
    // A length of 0 encodes 256: the 8-bit count 255+1 wraps to 0 and matches.
    assign last_s   = ((word_cnt_q + 8'd1) == blk_len_q);

    // State and frame-context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            seed_lo_q  <= 32'h0000_0000;
            seed_hi_q  <= 32'h0000_0000;
            blk_len_q  <= 8'd0;
            word_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            seed_lo_q  <= seed_lo_d;
            seed_hi_q  <= seed_hi_d;
            blk_len_q  <= blk_len_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Next-state, configuration latch and word counter update
    always_comb begin
        state_d    = state_q;
        seed_lo_d  = seed_lo_q;
        seed_hi_d  = seed_hi_q;
        blk_len_d  = blk_len_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seed_lo_d  = cfg_seed_lo;
                    seed_hi_d  = cfg_seed_hi;
                    blk_len_d  = cfg_blk_len;
                    word_cnt_d = 8'd0;
                    state_d    = ST_SEED_LO;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SEED_LO: state_d = ST_SEED_HI;
            ST_SEED_HI: state_d = ST_RUN;
            ST_RUN: begin
                if (accept_s) begin
                    word_cnt_d = word_cnt_q + 8'd1;
                    if (last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        ready_s       = 1'b0;
        sel_write_s   = 1'b0;
        sel_addr_s    = 12'h000;
        sel_lfsrdin_s = 32'h0000_0000;
        busy_s        = 1'b1;
        done_s        = 1'b0;
        case (state_q)
            ST_IDLE: busy_s = 1'b0;
            ST_SEED_LO: begin
                sel_write_s   = 1'b1;
                sel_addr_s    = 12'h068;
                sel_lfsrdin_s = seed_lo_q;
            end
            ST_SEED_HI: begin
                sel_write_s   = 1'b1;
                sel_addr_s    = 12'h069;
                sel_lfsrdin_s = seed_hi_q;
            end
            ST_RUN:  ready_s = 1'b1;
            ST_DONE: done_s  = 1'b1;
            default: busy_s  = 1'b0;
        endcase
    end

    assign s_ready     = ready_s;
    // Only RUN raises ready, so the step request can never overlap a seed write.
    assign sel_enable  = accept_s;
    assign sel_bits    = accept_s ? s_data : 10'h000;
    assign sel_write   = sel_write_s;
    assign sel_addr    = sel_addr_s;
    assign sel_lfsrdin = sel_lfsrdin_s;
    assign busy        = busy_s;
    assign done        = done_s;
    assign word_cnt    = word_cnt_q;

`ifdef SCR_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter, advances on the edge that leaves DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= 16'h0000;
        end else if (state_q == ST_DONE) begin
            frame_cnt_q <= frame_cnt_q + 16'h0001;
        end else begin
            frame_cnt_q <= frame_cnt_q;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    // Frame counter not built.
`endif

endmodule

// File: tb/tb_scrambler_ctrl.sv
module tb_scrambler_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] cfg_seed_lo;
    logic [31:0] cfg_seed_hi;
    logic [7:0]  cfg_blk_len;
    logic        s_valid;
    logic [9:0]  s_data;
    logic        s_ready;
    logic        sel_enable;
    logic [9:0]  sel_bits;
    logic        sel_write;
    logic [11:0] sel_addr;
    logic [31:0] sel_lfsrdin;
    logic        busy;
    logic        done;
    logic [7:0]  word_cnt;
`ifdef SCR_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int exp_frames = 0;
    logic [9:0] pat [4] = '{10'h3FF, 10'h001, 10'h155, 10'h2AA};

    always #5 clk = ~clk;

    scrambler_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_seed_lo(cfg_seed_lo), .cfg_seed_hi(cfg_seed_hi), .cfg_blk_len(cfg_blk_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .sel_enable(sel_enable), .sel_bits(sel_bits),
        .sel_write(sel_write), .sel_addr(sel_addr), .sel_lfsrdin(sel_lfsrdin),
        .busy(busy), .done(done), .word_cnt(word_cnt)
`ifdef SCR_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},    64'(busy), 64'd0);
        chk({tag, "_done"},    64'(done), 64'd0);
        chk({tag, "_ready"},   64'(s_ready), 64'd0);
        chk({tag, "_en"},      64'(sel_enable), 64'd0);
        chk({tag, "_bits"},    64'(sel_bits), 64'd0);
        chk({tag, "_wr"},      64'(sel_write), 64'd0);
        chk({tag, "_addr"},    64'(sel_addr), 64'd0);
        chk({tag, "_din"},     64'(sel_lfsrdin), 64'd0);
`ifdef SCR_FRAME_CNT_EN
        chk({tag, "_frames"},  64'(frame_cnt), 64'(exp_frames % 65536));
`endif
    endtask

    // One complete frame, entered in an IDLE cycle. mode: 0 random valid,
    // 1 valid every other cycle with the fixed data table, 2 continuous valid.
    task automatic run_frame(input logic [31:0] lo, input logic [31:0] hi,
                             input logic [7:0] len, input bit hold_start, input int mode);
        int   n;
        int   acc;
        int   cyc;
        logic v;
        logic [9:0] d;
        n   = (len == 8'd0) ? 256 : int'(len);
        acc = 0;
        cyc = 0;
        chk_idle("pre");
        start = 1'b1; cfg_seed_lo = lo; cfg_seed_hi = hi; cfg_blk_len = len; s_valid = 1'b0;
        step();
        // Seed writes; cfg is scrambled to show the latched copy is used.
        start = hold_start; cfg_seed_lo = $urandom; cfg_seed_hi = $urandom;
        cfg_blk_len = 8'($urandom); s_valid = 1'b1; s_data = 10'($urandom);
        #1;
        chk("lo_wr",   64'(sel_write), 64'd1);
        chk("lo_addr", 64'(sel_addr), 64'h068);
        chk("lo_din",  64'(sel_lfsrdin), 64'(lo));
        chk("lo_busy", 64'(busy), 64'd1);
        chk("lo_rdy",  64'(s_ready), 64'd0);
        chk("lo_en",   64'(sel_enable), 64'd0);
        chk("lo_cnt",  64'(word_cnt), 64'd0);
        step();
        chk("hi_wr",   64'(sel_write), 64'd1);
        chk("hi_addr", 64'(sel_addr), 64'h069);
        chk("hi_din",  64'(sel_lfsrdin), 64'(hi));
        chk("hi_rdy",  64'(s_ready), 64'd0);
        chk("hi_en",   64'(sel_enable), 64'd0);
        step();
        while (acc < n) begin
            if (cyc > 3000) begin
                chk("run_timeout", 64'(acc), 64'(n));
                break;
            end
            case (mode)
                1:       v = (cyc % 2 == 0);
                2:       v = 1'b1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = (mode == 1) ? pat[acc % 4] : 10'($urandom);
            s_valid = v; s_data = d;
            #1;
            chk("run_rdy",  64'(s_ready), 64'd1);
            chk("run_en",   64'(sel_enable), 64'(v));
            chk("run_bits", 64'(sel_bits), v ? 64'(d) : 64'd0);
            chk("run_wr",   64'(sel_write), 64'd0);
            chk("run_addr", 64'(sel_addr), 64'd0);
            chk("run_busy", 64'(busy), 64'd1);
            chk("run_done", 64'(done), 64'd0);
            chk("run_cnt",  64'(word_cnt), 64'(acc % 256));
            step();
            if (v) acc++;
            cyc++;
        end
        s_valid = 1'b1; s_data = 10'($urandom);
        #1;
        chk("dn_done", 64'(done), 64'd1);
        chk("dn_busy", 64'(busy), 64'd1);
        chk("dn_rdy",  64'(s_ready), 64'd0);
        chk("dn_en",   64'(sel_enable), 64'd0);
        chk("dn_cnt",  64'(word_cnt), 64'(n % 256));
        exp_frames++;
        step();
        s_valid = 1'b0;
        #1;
        chk_idle("post");
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = 10'h3FF;
        cfg_seed_lo = 32'hFFFF_FFFF; cfg_seed_hi = 32'hFFFF_FFFF; cfg_blk_len = 8'd7;
        step();
        step();
        chk_idle("rst");
        chk("rst_cnt", 64'(word_cnt), 64'd0);
        rst = 1'b0; start = 1'b0; s_valid = 1'b0;
        #1;

        run_frame(32'hDEADBEEF, 32'h01234567, 8'd4, 1'b0, 1);
        chk("f1_cnt", 64'(word_cnt), 64'd4);
        for (int i = 0; i < 3; i++) begin
            run_frame($urandom, $urandom, 8'($urandom_range(1, 20)), 1'b0, 0);
        end

        // Reset in the middle of a frame.
        start = 1'b1; cfg_blk_len = 8'd4; cfg_seed_lo = $urandom; cfg_seed_hi = $urandom;
        step();
        start = 1'b0;
        step();
        step();
        s_valid = 1'b1; s_data = 10'h123;
        step();
        step();
        chk("mid_cnt", 64'(word_cnt), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0; s_valid = 1'b0;
        exp_frames = 0;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_cnt", 64'(word_cnt), 64'd0);
        run_frame(32'hA5A5_0F0F, 32'h5A5A_F0F0, 8'd4, 1'b0, 0);

        // blk_len 0 means 256 words.
        run_frame($urandom, $urandom, 8'd0, 1'b0, 2);
        chk("f256_cnt", 64'(word_cnt), 64'd0);

        // start held high across a frame and into IDLE.
        run_frame($urandom, $urandom, 8'd3, 1'b1, 0);
        run_frame($urandom, $urandom, 8'd2, 1'b0, 0);

        // Three back-to-back single-word frames.
        exp_frames = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk_idle("bb_rst");
        run_frame($urandom, $urandom, 8'd1, 1'b1, 2);
        run_frame($urandom, $urandom, 8'd1, 1'b1, 2);
        run_frame($urandom, $urandom, 8'd1, 1'b0, 2);
`ifdef SCR_FRAME_CNT_EN
        chk("frames3", 64'(frame_cnt), 64'd3);
`endif
        chk("bb_cnt", 64'(word_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scrambler_ctrl.md
SCRAMBLER_CTRL -- requirements
Module: scrambler_ctrl

Interface
REQ-001 Ports SHALL be: clk  in  1  single clock, all logic on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 start  in  1  frame start pulse; honoured only in IDLE.
REQ-004 cfg_seed_lo  in  32  / cfg_seed_hi  in  32  LFSR seed words [31:0] / [63:32].
REQ-005 cfg_blk_len  in  8  10-bit words per frame; 0 means 256.
REQ-006 s_valid  in  1,  s_data  in  10,  s_ready  out  1  input word stream handshake.
REQ-007 sel_enable  out  1,  sel_bits  out  10  step request and bits to the scrambler datapath.
REQ-008 sel_write  out  1,  sel_addr  out  12,  sel_lfsrdin  out  32  seed register write port to the datapath.
REQ-009 busy  out  1,  done  out  1,  word_cnt  out  8  status.

Function
REQ-010 FSM states SHALL be IDLE, SEED_LO, SEED_HI, RUN, DONE; state register is one-hot or encoded at implementer's choice.
REQ-011 IDLE: start=1 latches cfg_seed_lo, cfg_seed_hi, cfg_blk_len, clears word_cnt, next state SEED_LO; cfg_* changes after the latch have no effect on the frame.
REQ-012 SEED_LO: sel_write=1, sel_addr=12'h068, sel_lfsrdin=latched seed_lo, for exactly one cycle; next SEED_HI.
REQ-013 SEED_HI: sel_write=1, sel_addr=12'h069, sel_lfsrdin=latched seed_hi, for exactly one cycle; next RUN.
REQ-014 Outside SEED_LO/SEED_HI: sel_write=0, sel_addr=12'h000, sel_lfsrdin=0.
REQ-015 RUN: s_ready=1; a word is accepted in a cycle where s_valid & s_ready.
REQ-016 sel_enable SHALL equal s_valid & s_ready combinationally; sel_bits = s_data when sel_enable=1, else 10'h000.
REQ-017 sel_enable and sel_write SHALL never be high in the same cycle.
REQ-018 Each accepted word increments word_cnt (8-bit, wraps 255->0) on the following edge.
REQ-019 Acceptance of word number N (N = latched blk_len, 256 if 0) SHALL move FSM to DONE; s_valid stalls of any length in RUN are tolerated with no timeout.
REQ-020 DONE: done=1 for exactly one cycle, s_ready=0; next IDLE.
REQ-021 busy=1 in every state except IDLE.
REQ-022 Latency: start at edge T -> sel_write high in cycles T+1, T+2; s_ready high from T+3; done high the cycle after the last accept.
REQ-023 start outside IDLE (including DONE) SHALL be ignored; a start in the cycle FSM returns to IDLE is honoured.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE regardless of state, including mid-frame, and has priority over start.
REQ-025 Reset values: busy=0, done=0, s_ready=0, sel_enable=0, sel_write=0, sel_addr=0, sel_lfsrdin=0, sel_bits=0, word_cnt=0, latched cfg=0.

Configuration
REQ-026 Macro SCR_FRAME_CNT_EN defined: extra output frame_cnt out 16, reset 0, incremented on the edge ending each DONE cycle, wraps 16'hFFFF->0.
REQ-027 SCR_FRAME_CNT_EN undefined: frame_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-028 rst, start with seed_lo=32'hDEADBEEF, seed_hi=32'h01234567, blk_len=4 -> writes 0x068/DEADBEEF then 0x069/01234567 on consecutive cycles, s_ready next cycle.
REQ-029 RUN with s_valid toggling every other cycle, data 10'h3FF,10'h001,10'h155,10'h2AA -> sel_enable only on accept cycles, sel_bits matches, done one cycle after 4th accept, word_cnt=4.
REQ-030 blk_len=0, continuous valid -> exactly 256 accepts, word_cnt wraps to 0, single done pulse.
REQ-031 rst asserted after 2 of 4 words -> next cycle IDLE, busy=0, s_ready=0, word_cnt=0; new start runs a full clean frame.
REQ-032 start held high throughout frame plus into IDLE -> no restart before done; new frame starts in first IDLE cycle.
REQ-033 With SCR_FRAME_CNT_EN, three back-to-back frames of blk_len=1 -> frame_cnt=3; without macro, build compiles with no frame_cnt port.
